switch_debounce: RTL and testbench

- Conditions the four raw Go Board push-button inputs.
- Per switch, it provides a debounced level plus single-cycle press and release events.
- Compile-time option: long-press event.
- Sits between the board pins and any consumer that acts on button edges (LED toggles, mode selects), so downstream logic never sees raw mechanical bounce.

---
 rtl/switch_debounce_if.sv | 26 ++
 rtl/switch_debounce.sv | 117 +++++++++++
 tb/tb_switch_debounce.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: bundles the raw switch pins and the conditioned
// outputs of switch_debounce. The master side drives the raw pins and
// observes the outputs; the slave side is the debouncer itself.
interface switch_debounce_if;
    logic [3:0] i_Switch;
    logic [3:0] o_Level;
    logic [3:0] o_Press;
    logic [3:0] o_Release;
    logic [3:0] o_Long;

    modport master (
        output i_Switch,
        input  o_Level,
        input  o_Press,
        input  o_Release,
        input  o_Long
    );

    modport slave (
        input  i_Switch,
        output o_Level,
        output o_Press,
        output o_Release,
        output o_Long
    );
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: four independent push-button lanes. Each lane has a
// two-flop synchronizer, a debounce counter producing a clean level, and
// registered one-cycle press/release pulses.
// Optional long-press pulse: define SWITCH_DEBOUNCE_LONG_PRESS_EN to build
// the per-lane hold counters; otherwise o_Long is tied to 4'b0000.
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int LONG_LIMIT     = 25000000
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    switch_debounce_if.slave bus
);

    localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    // Elaboration-time guard against out-of-range parameters.
    if (DEBOUNCE_LIMIT < 2) begin : g_bad_debounce
        $error("switch_debounce: DEBOUNCE_LIMIT must be >= 2");
    end
    if (LONG_LIMIT < 1) begin : g_bad_long
        $error("switch_debounce: LONG_LIMIT must be >= 1");
    end

    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [CW-1:0] cnt [4];
    logic [3:0]    level;
    logic [3:0]    press;
    logic [3:0]    rel;

    // Two-flop synchronizer bringing the asynchronous pins into i_Clk.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_a <= 4'b0000;
            sync_b <= 4'b0000;
        end else begin
            sync_a <= bus.i_Switch;
            sync_b <= sync_a;
        end
    end

    // Debounce counters, clean level and edge pulses; the pulse is set on
    // the same edge the level flips so it coincides with the new level.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= CNT_ZERO;
            end
            level <= 4'b0000;
            press <= 4'b0000;
            rel   <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                rel[i]   <= 1'b0;
                if (sync_b[i] == level[i]) begin
                    // Any return to the current level restarts the count.
                    cnt[i] <= CNT_ZERO;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= sync_b[i];
                    cnt[i]   <= CNT_ZERO;
                    press[i] <= sync_b[i];
                    rel[i]   <= ~sync_b[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign bus.o_Level   = level;
    assign bus.o_Press   = press;
    assign bus.o_Release = rel;

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
    localparam int HW = (LONG_LIMIT > 1) ? $clog2(LONG_LIMIT + 1) : 1;
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_LIMIT);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_LIMIT - 1);

    logic [HW-1:0] hold [4];
    logic [3:0]    long_ev;

    // Hold counters: count debounced-high cycles, saturate at the limit so
    // the pulse fires once per press; a debounced low re-arms the lane.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < 4; i++) begin
                hold[i] <= HOLD_ZERO;
            end
            long_ev <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                long_ev[i] <= 1'b0;
                if (!level[i]) begin
                    hold[i] <= HOLD_ZERO;
                end else if (hold[i] != HOLD_MAX) begin
                    hold[i]    <= hold[i] + HOLD_ONE;
                    long_ev[i] <= (hold[i] == HOLD_FIRE);
                end else begin
                    hold[i] <= hold[i];
                end
            end
        end
    end

    assign bus.o_Long = long_ev;
`else
    assign bus.o_Long = 4'b0000;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: scoreboard bench for switch_debounce with
// DEBOUNCE_LIMIT=4 and LONG_LIMIT=10. Expected output vectors are pushed per
// cycle when stimulus is applied and popped as each clock edge completes.
module tb_switch_debounce;

    localparam int DB = 4;
    localparam int LL = 10;

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t exp_q[$];

    switch_debounce_if bus ();

    switch_debounce #(
        .DEBOUNCE_LIMIT(DB),
        .LONG_LIMIT    (LL)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected trace for n edges after the pins move from old_v to new_v:
    // the new level and its event appear on edge DB+2. An optional long
    // pulse (bits lng_bits) is expected on edge long_at (0 = none).
    task automatic push_trace(input logic [3:0] old_v, input logic [3:0] new_v,
                              input int n, input logic [3:0] lng_bits,
                              input int long_at);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            e.level = (k < DB + 2) ? old_v : new_v;
            e.press = (k == DB + 2) ? (new_v & ~old_v) : 4'b0000;
            e.rel   = (k == DB + 2) ? (old_v & ~new_v) : 4'b0000;
            e.lng   = (k == long_at) ? lng_bits : 4'b0000;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t got;
        bus.i_Switch = 4'b0000;
        rst_n = 1'b0;
        push_trace(4'b0000, 4'b0000, 3, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset got=%h want=%h", got, e);
            end
        end
        rst_n = 1'b1;
        push_trace(4'b0000, 4'b0000, 3, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_idle got=%h want=%h", got, e);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] seq [3] = '{4'b0000, 4'b0001, 4'b0000};
        exp_t e;
        exp_t got;
        for (int p = 1; p < 3; p++) begin
            bus.i_Switch = seq[p];
            push_trace(seq[p-1], seq[p], 8, 4'b0000, 0);
            while (exp_q.size() > 0) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL clean_press phase=%0d got=%h want=%h", p, got, e);
                end
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        exp_t got;
        // Four 3-cycle bursts on lane 1 (1,0,1,0): never long enough to flip.
        push_trace(4'b0000, 4'b0000, 12, 4'b0000, 0);
        for (int b = 0; b < 12; b++) begin
            bus.i_Switch = ((b / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL bounce_glitch step=%0d got=%h want=%h", b, got, e);
            end
        end
        bus.i_Switch = 4'b0010;
        push_trace(4'b0000, 4'b0010, 8, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL bounce_hold got=%h want=%h", got, e);
            end
        end
        bus.i_Switch = 4'b0000;
        push_trace(4'b0010, 4'b0000, 8, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL bounce_release got=%h want=%h", got, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] seq [3] = '{4'b0000, 4'b1100, 4'b0000};
        exp_t e;
        exp_t got;
        for (int p = 1; p < 3; p++) begin
            bus.i_Switch = seq[p];
            push_trace(seq[p-1], seq[p], 8, 4'b0000, 0);
            while (exp_q.size() > 0) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL simultaneous phase=%0d got=%h want=%h", p, got, e);
                end
            end
        end
    endtask

    task automatic test_long_press();
        logic [3:0] lng_bits;
        exp_t e;
        exp_t got;
        lng_bits = LONG_ON ? 4'b0001 : 4'b0000;
        for (int r = 0; r < 2; r++) begin
            // Hold well past the limit: exactly one pulse LL edges after press.
            bus.i_Switch = 4'b0001;
            push_trace(4'b0000, 4'b0001, 30, lng_bits, DB + 2 + LL);
            while (exp_q.size() > 0) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL long_hold round=%0d got=%h want=%h", r, got, e);
                end
            end
            bus.i_Switch = 4'b0000;
            push_trace(4'b0001, 4'b0000, 8, 4'b0000, 0);
            while (exp_q.size() > 0) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL long_release round=%0d got=%h want=%h", r, got, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        exp_t got;
        // Lane 2 debounced high, then lane 0 starts counting.
        bus.i_Switch = 4'b0100;
        push_trace(4'b0000, 4'b0100, 8, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL midrst_pre got=%h want=%h", got, e);
            end
        end
        bus.i_Switch = 4'b0101;
        push_trace(4'b0100, 4'b0100, 4, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL midrst_count got=%h want=%h", got, e);
            end
        end
        // Asynchronous assertion between edges must clear outputs at once.
        rst_n = 1'b0;
        #1;
        got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
        total++;
        if (got !== 16'h0000) begin
            bad++;
            $display("FAIL midrst_async got=%h want=%h", got, 16'h0000);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_trace(4'b0000, 4'b0101, 8, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL midrst_after got=%h want=%h", got, e);
            end
        end
        bus.i_Switch = 4'b0000;
        push_trace(4'b0101, 4'b0000, 8, 4'b0000, 0);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            got = {bus.o_Level, bus.o_Press, bus.o_Release, bus.o_Long};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL midrst_release got=%h want=%h", got, e);
            end
        end
    endtask

    // Test sequence.
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_Switch = 4'b0000;
        #2;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_long_press();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
